matrix_loader: RTL and testbench

- Producer side of the packed-row matrix interface used by the determinant units.
- Accepts signed 8-bit elements one per handshake from the HPS-side input path, in row-major order.
- Assembles an NxN matrix (N = 2..MAX_DIM) into zero-padded packed rows.
- Presents the rows to the compute stage with a valid/ready hold until they are consumed.

---
 rtl/matrix_pkg.sv | 31 +++
 rtl/matrix_loader_if.sv | 32 +++
 rtl/matrix_loader_rc_counter.sv | 48 ++++
 rtl/matrix_loader.sv | 96 +++++++++
 tb/tb_matrix_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, loader state type and packed-row offset helpers
// Purpose: single source of matrix geometry so the loader and the determinant
//          units agree on where element (r,c) lives inside the packed rows bus.
// Contents: MAX_DIM, EW, CW constants; loader_state_e; row_msb/elem_msb/elem_lsb.
package matrix_pkg;

  localparam int MAX_DIM = 5;
  localparam int EW      = 8;
  localparam int CW      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } loader_state_e;

  // Row 0 sits at the top of the bus; each row is max_dim elements wide.
  function automatic int row_msb(input int max_dim, input int ew, input int r);
    return (max_dim - r) * max_dim * ew - 1;
  endfunction

  // Column 0 is the most significant element of its row.
  function automatic int elem_msb(input int max_dim, input int ew, input int r, input int c);
    return row_msb(max_dim, ew, r) - c * ew;
  endfunction

  function automatic int elem_lsb(input int max_dim, input int ew, input int r, input int c);
    return elem_msb(max_dim, ew, r, c) - ew + 1;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// rtl/matrix_loader_if.sv - element input, matrix output and control bundle of the loader
// Purpose: groups the loader's handshake and status signals.
// Signals: dim/start (load request), in_data/in_valid/in_ready (element stream),
//          rows/mat_valid/mat_ready (matrix handoff), busy/err (status).
// Modports: master = producer/consumer environment, slave = matrix_loader.
interface matrix_loader_if #(
  parameter int MAX_DIM = matrix_pkg::MAX_DIM,
  parameter int EW      = matrix_pkg::EW
);

  logic [2:0]                   dim;
  logic                         start;
  logic [EW-1:0]                in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [MAX_DIM*MAX_DIM*EW-1:0] rows;
  logic                         mat_valid;
  logic                         mat_ready;
  logic                         busy;
  logic                         err;

  modport master (
    output dim, start, in_data, in_valid, mat_ready,
    input  in_ready, rows, mat_valid, busy, err
  );

  modport slave (
    input  dim, start, in_data, in_valid, mat_ready,
    output in_ready, rows, mat_valid, busy, err
  );

endinterface

// File: rtl/matrix_loader_rc_counter.sv
// rtl/matrix_loader_rc_counter.sv - row-major row/col counter with programmable wrap
// Purpose: tracks the (row,col) slot of the next element of a dim_q x dim_q load.
// Ports: clk, rst (sync, active-high), i_clear (restart at 0,0), i_advance (one
//        element accepted), i_dim_q (wrap point), o_row/o_col (current slot),
//        o_last (current slot is the final element).
module rc_counter
  import matrix_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_advance,
  input  logic [CW-1:0] i_dim_q,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_end;
  logic          w_col_end;
  logic          w_last;

  assign w_end     = i_dim_q - CW'(1);
  assign w_col_end = (r_col == w_end);
  assign w_last    = w_col_end && (r_row == w_end);

  // After the final element both counters return to 0 so they never exceed dim_q-1.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_last ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_last;

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - assembles a row-major element stream into zero-padded packed rows
// Purpose: IDLE/LOAD/HOLD producer for the determinant units' packed-row matrix bus.
// Ports: clk, rst (sync, active-high), bus (matrix_loader_if.slave):
//        dim/start request a load, in_data/in_valid/in_ready carry elements,
//        rows/mat_valid/mat_ready hand off the matrix, busy/err report status.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int MAX_DIM = matrix_pkg::MAX_DIM,
  parameter int EW      = matrix_pkg::EW
) (
  input  logic           clk,
  input  logic           rst,
  matrix_loader_if.slave bus
);

  localparam int RW    = MAX_DIM * MAX_DIM * EW;
  localparam int LSB_W = $clog2(RW);

  localparam logic [1:0]    S_IDLE  = ST_IDLE;
  localparam logic [1:0]    S_LOAD  = ST_LOAD;
  localparam logic [1:0]    S_HOLD  = ST_HOLD;
  localparam logic [CW-1:0] DIM_MIN = CW'(2);
  localparam logic [CW-1:0] DIM_MAX = CW'(MAX_DIM);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_dim_q;
  logic [RW-1:0]   r_rows;
  logic            r_err;

  logic            w_dim_ok;
  logic            w_accept;
  logic            w_beat;
  logic [CW-1:0]   w_row;
  logic [CW-1:0]   w_col;
  logic            w_last;
  logic [LSB_W-1:0] w_lsb;

  assign w_dim_ok = (bus.dim >= DIM_MIN) && (bus.dim <= DIM_MAX);
  assign w_accept = (r_state == S_IDLE) && bus.start && w_dim_ok;
  assign w_beat   = (r_state == S_LOAD) && bus.in_valid;
  assign w_lsb    = LSB_W'(elem_lsb(MAX_DIM, EW, int'(w_row), int'(w_col)));

  rc_counter u_rc (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_advance(w_beat),
    .i_dim_q  (r_dim_q),
    .o_row    (w_row),
    .o_col    (w_col),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dim_q <= '0;
      r_rows  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_dim_ok) begin
              r_dim_q <= bus.dim;
              r_rows  <= '0;
              r_state <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            r_rows[w_lsb +: EW] <= bus.in_data;
            if (w_last) r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // rows is left intact after handoff; only the next accepted start clears it.
          if (bus.mat_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_LOAD);
  assign bus.mat_valid = (r_state == S_HOLD);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rows      = r_rows;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - self-checking bench for matrix_loader against a row-major matrix model
module tb_matrix_loader;

  localparam int N  = 5;
  localparam int EW = 8;
  localparam int W  = N * N * EW;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [EW-1:0] model [N][N];
  logic [EW-1:0] vals  [N*N];
  int            cur_d;

  matrix_loader_if bus ();

  matrix_loader dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Matrix as a flat row-major concatenation: first element is the MSB, cells outside d x d are 0.
  function automatic logic [W-1:0] pack(input int d);
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v = {v[W-EW-1:0], ((r < d) && (c < d)) ? model[r][c] : 8'h00};
    return v;
  endfunction

  task automatic do_start(input int d);
    bus.dim   = 3'(d);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_rows_cleared", bus.rows, 0);
  endtask

  task automatic rand_vals(input int n);
    for (int k = 0; k < n; k++) vals[k] = 8'($urandom_range(0, 255));
  endtask

  // every>0: stall slen cycles after each every-th element; every<0: random stalls.
  task automatic feed(input int d, input int every, input int slen, input int inj);
    int n;
    int ns;
    n = d * d;
    cur_d = d;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) model[r][c] = 8'h00;
    for (int k = 0; k < n; k++) model[k / d][k % d] = vals[k];
    for (int k = 0; k < n; k++) begin
      chk("load_in_ready", bus.in_ready, 1);
      chk("load_no_early_valid", bus.mat_valid, 0);
      bus.in_data  = vals[k];
      bus.in_valid = 1'b1;
      if (k == inj) begin
        bus.start = 1'b1;
        bus.dim   = 3'd4;
      end
      step();
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      ns = 0;
      if (k < n - 1) begin
        if (every > 0 && ((k + 1) % every) == 0) ns = slen;
        else if (every < 0) ns = int'($urandom_range(0, 2));
      end
      for (int s = 0; s < ns; s++) begin
        step();
        chk("stall_no_valid", bus.mat_valid, 0);
      end
    end
    chk("done_mat_valid", bus.mat_valid, 1);
    chk("done_in_ready_low", bus.in_ready, 0);
    chk("done_rows", bus.rows, pack(d));
  endtask

  task automatic release_mat();
    bus.mat_ready = 1'b1;
    step();
    bus.mat_ready = 1'b0;
    chk("release_idle", bus.busy, 0);
    chk("release_valid_low", bus.mat_valid, 0);
    chk("release_rows_kept", bus.rows, pack(cur_d));
  endtask

  initial begin
    int det;
    int d;
    n_checks      = 0;
    n_errors      = 0;
    cur_d         = 0;
    rst           = 1'b1;
    bus.dim       = '0;
    bus.start     = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.mat_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mat_valid", bus.mat_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rows", bus.rows, 0);
    rst = 1'b0;
    step();

    // 2x2 directed load feeding a 2x2 determinant unit
    vals[0] = 8'd3; vals[1] = 8'hFE; vals[2] = 8'd5; vals[3] = 8'd4;
    do_start(2);
    feed(2, 0, 0, -1);
    chk("r0_top16", bus.rows[W-1 -: 16], 16'h03FE);
    chk("r1_top16", bus.rows[W-N*EW-1 -: 16], 16'h0504);
    det = $signed(bus.rows[199:192]) * $signed(bus.rows[151:144])
        - $signed(bus.rows[191:184]) * $signed(bus.rows[159:152]);
    chk("det2", det, 22);
    release_mat();

    // 5x5 with 3-cycle stalls after every 4th element
    for (int k = 0; k < 25; k++) vals[k] = 8'(k + 1);
    do_start(5);
    feed(5, 4, 3, -1);
    chk("e44", bus.rows[7:0], 8'd25);
    release_mat();

    // illegal dimensions
    foreach (vals[i]) if (i == 0) d = 1;
    for (int t = 0; t < 2; t++) begin
      d = (t == 0) ? 1 : 6;
      bus.dim   = 3'(d);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("illegal_err_pulse", bus.err, 1);
      chk("illegal_idle", bus.busy, 0);
      chk("illegal_in_ready", bus.in_ready, 0);
      chk("illegal_rows_kept", bus.rows, pack(5));
      step();
      chk("illegal_err_one_cycle", bus.err, 0);
    end

    // backpressure on the matrix handoff
    rand_vals(9);
    do_start(3);
    feed(3, 0, 0, -1);
    for (int t = 0; t < 10; t++) begin
      step();
      chk("bp_valid", bus.mat_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_rows", bus.rows, pack(3));
    end
    bus.mat_ready = 1'b1;
    step();
    bus.mat_ready = 1'b0;
    chk("bp_idle", bus.busy, 0);
    rand_vals(4);
    do_start(2);
    feed(2, 0, 0, -1);
    release_mat();

    // reset in the middle of a 3x3 load
    do_start(3);
    for (int k = 0; k < 3; k++) begin
      bus.in_data  = 8'($urandom_range(1, 255));
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rows", bus.rows, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_valid", bus.mat_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_err", bus.err, 0);
    rand_vals(9);
    do_start(3);
    feed(3, 0, 0, -1);
    release_mat();

    // start during LOAD and during HOLD is ignored
    rand_vals(9);
    do_start(3);
    feed(3, 0, 0, 2);
    bus.dim   = 3'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("hold_start_ignored_valid", bus.mat_valid, 1);
    chk("hold_start_ignored_rows", bus.rows, pack(3));
    release_mat();

    // randomized loads with random stalls and handoff delay
    for (int t = 0; t < 6; t++) begin
      d = int'($urandom_range(2, 5));
      rand_vals(d * d);
      do_start(d);
      feed(d, -1, 0, -1);
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        step();
        chk("rand_hold_valid", bus.mat_valid, 1);
      end
      release_mat();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
